// File: rtl/tile_order_shuffler.sv
// Produces random edge/center tile permutations by running a Fisher-Yates shuffle
// one swap per cycle. Random bits come from a free-running LFSR.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last published orders
// INIT   | load identity into the working arrays and set both indices
// SHUF_E | swap edge slot i_e with a random slot in 0..i_e
// SHUF_C | swap center slot i_c with a random slot in 0..i_c, then publish
// DONE   | one-cycle done pulse
module tile_order_shuffler #(
  parameter int          EDGE_N   = 24,
  parameter int          EDGE_W   = 5,
  parameter int          CENTER_N = 12,
  parameter int          CENTER_W = 4,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         valid,
  output logic [EDGE_N*EDGE_W-1:0]     edge_order,
  output logic [CENTER_N*CENTER_W-1:0] center_order
);

  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [2:0] {IDLE, INIT, SHUF_E, SHUF_C, DONE} state_t;

  state_t              state, state_nxt;
  logic [15:0]         lfsr, lfsr_nxt;
  logic [7:0]          r;
  logic [EDGE_W-1:0]   i_e, i_e_p1, j_e;
  logic [CENTER_W-1:0] i_c, i_c_p1, j_c;
  logic [EDGE_W+7:0]   prod_e;
  logic [CENTER_W+7:0] prod_c;
  logic [EDGE_W-1:0]   w_e     [EDGE_N];
  logic [EDGE_W-1:0]   w_e_swp [EDGE_N];
  logic [CENTER_W-1:0] w_c     [CENTER_N];
  logic [CENTER_W-1:0] w_c_swp [CENTER_N];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = INIT;
      INIT:    state_nxt = SHUF_E;
      SHUF_E:  if (i_e == EDGE_W'(1)) state_nxt = SHUF_C;
      SHUF_C:  if (i_c == CENTER_W'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Galois LFSR, mask 16'hB400, shifting right
  always_comb begin
    lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    r        = lfsr[7:0];
  end

  // Scale r into 0..i by taking the top bits of r*(i+1)
  always_comb begin
    i_e_p1 = i_e + EDGE_W'(1);
    i_c_p1 = i_c + CENTER_W'(1);
    prod_e = {{EDGE_W{1'b0}}, r} * {8'h00, i_e_p1};
    prod_c = {{CENTER_W{1'b0}}, r} * {8'h00, i_c_p1};
    j_e    = EDGE_W'(prod_e >> 8);
    j_c    = CENTER_W'(prod_c >> 8);
  end

  always_comb begin
    w_e_swp      = w_e;
    w_e_swp[i_e] = w_e[j_e];
    w_e_swp[j_e] = w_e[i_e];
    w_c_swp      = w_c;
    w_c_swp[i_c] = w_c[j_c];
    w_c_swp[j_c] = w_c[i_c];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr  <= LFSR_INIT;
      i_e   <= '0;
      i_c   <= '0;
      valid <= 1'b0;
      for (int k = 0; k < EDGE_N; k++) begin
        w_e[k]                          <= EDGE_W'(k);
        edge_order[k*EDGE_W +: EDGE_W]  <= EDGE_W'(k);
      end
      for (int k = 0; k < CENTER_N; k++) begin
        w_c[k]                              <= CENTER_W'(k);
        center_order[k*CENTER_W +: CENTER_W] <= CENTER_W'(k);
      end
    end else begin
      lfsr <= lfsr_nxt;
      case (state)
        INIT: begin
          for (int k = 0; k < EDGE_N; k++)   w_e[k] <= EDGE_W'(k);
          for (int k = 0; k < CENTER_N; k++) w_c[k] <= CENTER_W'(k);
          i_e <= EDGE_W'(EDGE_N - 1);
          i_c <= CENTER_W'(CENTER_N - 1);
        end
        SHUF_E: begin
          w_e <= w_e_swp;
          if (i_e != EDGE_W'(1)) i_e <= i_e - EDGE_W'(1);
        end
        SHUF_C: begin
          w_c <= w_c_swp;
          if (i_c != CENTER_W'(1)) begin
            i_c <= i_c - CENTER_W'(1);
          end else begin
            // Publish including this cycle's final swap so DONE shows the new orders
            for (int k = 0; k < EDGE_N; k++)
              edge_order[k*EDGE_W +: EDGE_W] <= w_e[k];
            for (int k = 0; k < CENTER_N; k++)
              center_order[k*CENTER_W +: CENTER_W] <= w_c_swp[k];
            valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
